// File: rtl/var_delay_line.sv
// Runtime-programmable delay line: samples enter a circular buffer and are read back D enabled samples later.
// Fill FSM keeps o_valid low until D fresh samples exist; latency is D enables plus one output register.
module var_delay_line #(
    parameter int DATA_W        = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DLY_W         = 5,
    parameter int DEFAULT_DELAY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] iv_data,
    input  logic              i_delay_load,
    input  logic [DLY_W-1:0]  iv_delay,
    output logic [DATA_W-1:0] ov_data,
    output logic              o_valid,
    output logic [DLY_W-1:0]  ov_delay
);

    localparam int AW = $clog2(MAX_DELAY);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [MAX_DELAY];

    state_t            state_q;
    logic [AW-1:0]     wp_q;
    logic [DLY_W-1:0]  fc_q;
    logic [DLY_W-1:0]  delay_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    logic [DLY_W-1:0]  delay_d;
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd_dat;

    always_comb begin
        delay_d = iv_delay;
        if (iv_delay == '0) begin
            delay_d = DLY_W'(1);
        end else if (iv_delay > DLY_W'(MAX_DELAY)) begin
            delay_d = DLY_W'(MAX_DELAY);
        end
    end

    // D == MAX_DELAY truncates to 0 here, so ra lands on wp and returns the entry about to be overwritten.
    assign ra     = wp_q - delay_q[AW-1:0];
    assign rd_dat = mem[ra];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            mem[wp_q] <= iv_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FILL;
            wp_q    <= '0;
            fc_q    <= '0;
            delay_q <= DLY_W'(DEFAULT_DELAY);
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (i_en) begin
                wp_q <= wp_q + 1'b1;
            end
            // A load restarts the fill; a sample arriving on the same edge counts toward it.
            if (i_delay_load) begin
                delay_q <= delay_d;
                state_q <= FILL;
                data_q  <= '0;
                valid_q <= 1'b0;
                fc_q    <= {{(DLY_W-1){1'b0}}, i_en};
            end else if (i_en) begin
                case (state_q)
                    FILL: begin
                        fc_q <= fc_q + 1'b1;
                        if (fc_q == delay_q) begin
                            data_q  <= rd_dat;
                            valid_q <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        data_q <= rd_dat;
                    end
                    default: begin
                        state_q <= FILL;
                    end
                endcase
            end
        end
    end

    assign ov_data  = data_q;
    assign o_valid  = valid_q;
    assign ov_delay = delay_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Bench for var_delay_line: a sample-history reference model predicts the output after every clock.
module tb_var_delay_line;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic [7:0] iv_data = '0;
    logic       i_delay_load = 1'b0;
    logic [4:0] iv_delay = '0;
    logic [7:0] ov_data;
    logic       o_valid;
    logic [4:0] ov_delay;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: every sample ever written, count since last load/reset, current delay.
    byte unsigned hist[$];
    int           m_cnt = 0;
    int           m_d = 2;
    logic         m_valid = 1'b0;
    logic [7:0]   m_data = '0;

    var_delay_line dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .iv_data      (iv_data),
        .i_delay_load (i_delay_load),
        .iv_delay     (iv_delay),
        .ov_data      (ov_data),
        .o_valid      (o_valid),
        .ov_delay     (ov_delay)
    );

    always #5 i_clk = ~i_clk;

    function automatic int clamp(input int req);
        if (req == 0) return 1;
        if (req > 16) return 16;
        return req;
    endfunction

    // One clock: drive inputs, advance the model at the edge, leave #1 for the caller to compare.
    task automatic tick(input logic en, input logic [7:0] d, input logic ld, input logic [4:0] dl);
        i_en = en;
        iv_data = d;
        i_delay_load = ld;
        iv_delay = dl;
        @(posedge i_clk);
        if (en) hist.push_back(d);
        if (ld) begin
            m_d = clamp(int'(dl));
            m_cnt = en ? 1 : 0;
            m_valid = 1'b0;
            m_data = '0;
        end else if (en) begin
            m_cnt++;
            if (m_cnt >= m_d + 1) begin
                m_valid = 1'b1;
                m_data = hist[hist.size() - 1 - m_d];
            end
        end
        #1;
        i_en = 1'b0;
        i_delay_load = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_d = 2;
        m_valid = 1'b0;
        m_data = '0;
    endtask

    task automatic test_reset();
        model_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        tests_run++;
        if (ov_data !== 8'd0 || o_valid !== 1'b0 || ov_delay !== 5'd2) begin
            tests_failed++;
            $display("FAIL reset_state: got data=%0h valid=%0b delay=%0d, want 0 0 2", ov_data, o_valid, ov_delay);
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_default_fill();
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 8'(i), 1'b0, 5'd0);
            tests_run++;
            if (ov_data !== m_data || o_valid !== m_valid || ov_delay !== 5'(m_d)) begin
                tests_failed++;
                $display("FAIL default_fill[%0d]: got %0h/%0b/%0d want %0h/%0b/%0d", i, ov_data, o_valid, ov_delay, m_data, m_valid, m_d);
            end
            if (i == 3) begin
                tests_run++;
                if (ov_data !== 8'd1 || o_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL default_first_valid: got %0h/%0b want 1/1", ov_data, o_valid);
                end
            end
        end
    endtask

    task automatic test_load5();
        tick(1'b0, 8'h00, 1'b1, 5'd5);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 8'(8'h10 + i), 1'b0, 5'd0);
            tests_run++;
            if (ov_data !== m_data || o_valid !== m_valid || ov_delay !== 5'd5) begin
                tests_failed++;
                $display("FAIL load5[%0d]: got %0h/%0b/%0d want %0h/%0b/5", i, ov_data, o_valid, ov_delay, m_data, m_valid);
            end
            if (i == 5) begin
                tests_run++;
                if (ov_data !== 8'h10 || o_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL load5_first_valid: got %0h/%0b want 10/1", ov_data, o_valid);
                end
            end
        end
    endtask

    task automatic test_gaps();
        tick(1'b1, 8'h50, 1'b1, 5'd3);
        for (int i = 0; i < 20; i++) begin
            tick(i[0] == 1'b0, 8'($urandom), 1'b0, 5'd0);
            tests_run++;
            if (ov_data !== m_data || o_valid !== m_valid) begin
                tests_failed++;
                $display("FAIL gaps[%0d]: got %0h/%0b want %0h/%0b", i, ov_data, o_valid, m_data, m_valid);
            end
        end
    endtask

    task automatic test_clamp_wrap();
        tick(1'b0, 8'h00, 1'b1, 5'd0);
        tests_run++;
        if (ov_delay !== 5'd1) begin
            tests_failed++;
            $display("FAIL clamp_zero: got %0d want 1", ov_delay);
        end
        tick(1'b0, 8'h00, 1'b1, 5'd31);
        tests_run++;
        if (ov_delay !== 5'd16) begin
            tests_failed++;
            $display("FAIL clamp_max: got %0d want 16", ov_delay);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 8'(8'h80 + i), 1'b0, 5'd0);
            tests_run++;
            if (ov_data !== m_data || o_valid !== m_valid || (i >= 16 && ov_data !== 8'(8'h80 + i - 16))) begin
                tests_failed++;
                $display("FAIL wrap16[%0d]: got %0h/%0b want %0h/%0b", i, ov_data, o_valid, m_data, m_valid);
            end
        end
    endtask

    task automatic test_load_with_enable();
        tick(1'b0, 8'h00, 1'b1, 5'd4);
        for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 5'd0);
        tick(1'b1, 8'hAA, 1'b1, 5'd2);
        tests_run++;
        if (o_valid !== 1'b0 || ov_data !== 8'h00 || ov_delay !== 5'd2) begin
            tests_failed++;
            $display("FAIL load_en_edge: got %0h/%0b/%0d want 0/0/2", ov_data, o_valid, ov_delay);
        end
        tick(1'b1, 8'hBB, 1'b0, 5'd0);
        tick(1'b1, 8'hCC, 1'b0, 5'd0);
        tests_run++;
        if (ov_data !== 8'hAA || o_valid !== 1'b1 || ov_data !== m_data) begin
            tests_failed++;
            $display("FAIL load_en_refill: got %0h/%0b want aa/1", ov_data, o_valid);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 8'h00, 1'b1, 5'd4);
        for (int i = 0; i < 8; i++) tick(1'b1, 8'($urandom), 1'b0, 5'd0);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (ov_data !== 8'd0 || o_valid !== 1'b0 || ov_delay !== 5'd2) begin
            tests_failed++;
            $display("FAIL reset_async: got %0h/%0b/%0d want 0/0/2", ov_data, o_valid, ov_delay);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'h30 + i), 1'b0, 5'd0);
            tests_run++;
            if (ov_data !== m_data || o_valid !== m_valid || ov_delay !== 5'd2) begin
                tests_failed++;
                $display("FAIL reset_refill[%0d]: got %0h/%0b/%0d want %0h/%0b/2", i, ov_data, o_valid, ov_delay, m_data, m_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 24) == 0, 5'($urandom_range(0, 31)));
            tests_run++;
            if (ov_data !== m_data || o_valid !== m_valid || ov_delay !== 5'(m_d)) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %0h/%0b/%0d want %0h/%0b/%0d", i, ov_data, o_valid, ov_delay, m_data, m_valid, m_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_fill();
        test_load5();
        test_gaps();
        test_clamp_wrap();
        test_load_with_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
